// File: rtl/output_port_arbiter.sv
// Per-output-port scheduler: round-robin arbitration among input link controllers,
// gated by downstream packet credits. A grant produces a one-cycle transfer strobe,
// then the crossbar select is held for the whole packet.
module output_port_arbiter #(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned PACKET_FLITS = 5,
    parameter int unsigned CREDITS      = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             request_din,
    input  logic                             credit_in_din,
    output logic [NUM_PORTS-1:0]             transfer_strobe_dout,
    output logic [NUM_PORTS-1:0]             port_select_dout,
    output logic                             port_busy_dout,
    output logic [$clog2(CREDITS+1)-1:0]     credit_count_dout,
    output logic                             credit_overflow_dout
);

    localparam int unsigned PtrW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned FlitW = (PACKET_FLITS > 1) ? $clog2(PACKET_FLITS) : 1;
    localparam int unsigned CntW  = $clog2(CREDITS + 1);

    localparam logic [FlitW-1:0] FlitLast  = FlitW'(PACKET_FLITS - 1);
    localparam logic [PtrW-1:0]  PtrLast   = PtrW'(NUM_PORTS - 1);
    localparam logic [CntW-1:0]  CreditMax = CntW'(CREDITS);

    typedef enum logic [0:0] {StIdle, StTransfer} state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        rr_q, rr_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic [FlitW-1:0]       flit_q, flit_d;
    logic [CntW-1:0]        credit_q, credit_d;
    logic                   overflow_q, overflow_d;

    logic                   winner_valid;
    logic [PtrW-1:0]        winner_idx;
    logic                   do_grant;
    int unsigned            idx;

    // Round-robin search: first requester at or above rr_q, wrapping.
    always_comb begin
        winner_valid = 1'b0;
        winner_idx   = '0;
        idx          = 0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!winner_valid && request_din[idx[PtrW-1:0]]) begin
                winner_valid = 1'b1;
                winner_idx   = idx[PtrW-1:0];
            end
        end
    end

    // Next-state logic for the IDLE/TRANSFER scheduler.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        flit_d   = flit_q;
        do_grant = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Registered credit count gates arbitration; a credit arriving now waits.
                if (winner_valid && (credit_q != '0)) begin
                    do_grant            = 1'b1;
                    state_d             = StTransfer;
                    grant_d             = '0;
                    grant_d[winner_idx] = 1'b1;
                    flit_d              = FlitLast;
                    rr_d                = (winner_idx == PtrLast) ? '0 : winner_idx + 1'b1;
                end
            end
            StTransfer: begin
                if (flit_q == '0) begin
                    state_d = StIdle;
                    grant_d = '0;
                end else begin
                    flit_d = flit_q - 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                flit_d  = '0;
            end
        endcase
    end

    // Credit bookkeeping: grant consumes, credit_in returns, both together cancel.
    always_comb begin
        credit_d   = credit_q;
        overflow_d = overflow_q;
        if (do_grant && !credit_in_din) begin
            credit_d = credit_q - 1'b1;
        end else if (credit_in_din && !do_grant) begin
            if (credit_q == CreditMax) begin
                overflow_d = 1'b1;
            end else begin
                credit_d = credit_q + 1'b1;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            rr_q       <= '0;
            grant_q    <= '0;
            flit_q     <= '0;
            credit_q   <= CreditMax;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            flit_q     <= flit_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs: strobe only on the first transfer cycle, select for the whole packet.
    always_comb begin
        transfer_strobe_dout = '0;
        port_select_dout     = '0;
        port_busy_dout       = 1'b0;
        if (state_q == StTransfer) begin
            port_select_dout = grant_q;
            port_busy_dout   = 1'b1;
            if (flit_q == FlitLast) begin
                transfer_strobe_dout = grant_q;
            end
        end
        credit_count_dout    = credit_q;
        credit_overflow_dout = overflow_q;
    end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter. Inputs change and outputs are sampled on
// the falling edge, so each negedge corresponds to one cycle of the design.
module tb_output_port_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] request_din;
    logic       credit_in_din;
    logic [3:0] transfer_strobe_dout;
    logic [3:0] port_select_dout;
    logic       port_busy_dout;
    logic [2:0] credit_count_dout;
    logic       credit_overflow_dout;

    int n_checks;
    int n_errors;

    output_port_arbiter #(
        .NUM_PORTS   (4),
        .PACKET_FLITS(5),
        .CREDITS     (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .request_din         (request_din),
        .credit_in_din       (credit_in_din),
        .transfer_strobe_dout(transfer_strobe_dout),
        .port_select_dout    (port_select_dout),
        .port_busy_dout      (port_busy_dout),
        .credit_count_dout   (credit_count_dout),
        .credit_overflow_dout(credit_overflow_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        cycles(2);
        reset = 1'b1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b0;
        request_din   = 4'b0000;
        credit_in_din = 1'b0;
        cycles(2);
        reset = 1'b1;

        // Reset state
        check("rst_strobe", 32'(transfer_strobe_dout), 32'h0);
        check("rst_select", 32'(port_select_dout), 32'h0);
        check("rst_busy", 32'(port_busy_dout), 32'h0);
        check("rst_credit", 32'(credit_count_dout), 32'd4);
        check("rst_ovf", 32'(credit_overflow_dout), 32'h0);

        // 1: single request from port 2
        request_din = 4'b0100;
        cycles(1);
        check("t1_strobe_c1", 32'(transfer_strobe_dout), 32'h4);
        check("t1_select_c1", 32'(port_select_dout), 32'h4);
        check("t1_credit_c1", 32'(credit_count_dout), 32'd3);
        request_din = 4'b0000;
        for (int c = 2; c <= 5; c++) begin
            cycles(1);
            check("t1_strobe_off", 32'(transfer_strobe_dout), 32'h0);
            check("t1_select_hold", 32'(port_select_dout), 32'h4);
            check("t1_busy_hold", 32'(port_busy_dout), 32'h1);
        end
        cycles(1);
        check("t1_select_c6", 32'(port_select_dout), 32'h0);
        check("t1_busy_c6", 32'(port_busy_dout), 32'h0);
        check("t1_credit_c6", 32'(credit_count_dout), 32'd3);

        // 2: fairness with all four requesting, rr pointer reset to 0
        do_reset();
        request_din = 4'b1111;
        cycles(1);
        for (int k = 0; k < 5; k++) begin
            check("t2_grant_order", 32'(transfer_strobe_dout), 32'(4'b0001 << (k % 4)));
            check("t2_credit", 32'(credit_count_dout), 32'd3);
            credit_in_din = 1'b1;
            if (k == 4) request_din = 4'b0000;
            cycles(1);
            credit_in_din = 1'b0;
            cycles(4);
            check("t2_idle_gap", 32'(port_busy_dout), 32'h0);
            check("t2_no_strobe", 32'(transfer_strobe_dout), 32'h0);
            cycles(1);
        end
        check("t2_final_busy", 32'(port_busy_dout), 32'h0);
        check("t2_final_credit", 32'(credit_count_dout), 32'd4);

        // 3: credit exhaustion with a persistent requester on port 0 (rr now 1)
        request_din = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            cycles(1);
            check("t3_strobe", 32'(transfer_strobe_dout), 32'h1);
            check("t3_credit", 32'(credit_count_dout), 32'(3 - k));
            cycles(5);
        end
        cycles(3);
        check("t3_blocked_busy", 32'(port_busy_dout), 32'h0);
        check("t3_blocked_strobe", 32'(transfer_strobe_dout), 32'h0);
        check("t3_zero_credit", 32'(credit_count_dout), 32'd0);
        credit_in_din = 1'b1;
        cycles(1);
        credit_in_din = 1'b0;
        check("t3_no_same_cycle_grant", 32'(port_busy_dout), 32'h0);
        check("t3_credit_one", 32'(credit_count_dout), 32'd1);
        cycles(1);
        check("t3_grant_after_credit", 32'(transfer_strobe_dout), 32'h1);
        check("t3_credit_back_zero", 32'(credit_count_dout), 32'd0);
        request_din = 4'b0000;
        cycles(5);

        // 4: grant and credit_in in the same cycle at count 2 (rr now 1)
        credit_in_din = 1'b1;
        cycles(2);
        credit_in_din = 1'b0;
        check("t4_credit_two", 32'(credit_count_dout), 32'd2);
        request_din   = 4'b0010;
        credit_in_din = 1'b1;
        cycles(1);
        request_din   = 4'b0000;
        credit_in_din = 1'b0;
        check("t4_strobe", 32'(transfer_strobe_dout), 32'h2);
        check("t4_credit_net", 32'(credit_count_dout), 32'd2);
        cycles(5);

        // 5: overflow at full credit
        credit_in_din = 1'b1;
        cycles(2);
        credit_in_din = 1'b0;
        check("t5_credit_full", 32'(credit_count_dout), 32'd4);
        check("t5_ovf_clear", 32'(credit_overflow_dout), 32'h0);
        credit_in_din = 1'b1;
        cycles(1);
        credit_in_din = 1'b0;
        check("t5_credit_capped", 32'(credit_count_dout), 32'd4);
        check("t5_ovf_set", 32'(credit_overflow_dout), 32'h1);
        cycles(3);
        check("t5_ovf_sticky", 32'(credit_overflow_dout), 32'h1);

        // 6: reset in the third transfer cycle (rr now 2)
        request_din = 4'b0100;
        cycles(1);
        check("t6_strobe", 32'(transfer_strobe_dout), 32'h4);
        request_din = 4'b0000;
        cycles(2);
        check("t6_select_c3", 32'(port_select_dout), 32'h4);
        reset = 1'b0;
        #1;
        check("t6_rst_select", 32'(port_select_dout), 32'h0);
        check("t6_rst_busy", 32'(port_busy_dout), 32'h0);
        check("t6_rst_strobe", 32'(transfer_strobe_dout), 32'h0);
        check("t6_rst_credit", 32'(credit_count_dout), 32'd4);
        check("t6_rst_ovf", 32'(credit_overflow_dout), 32'h0);
        cycles(1);
        reset = 1'b1;
        request_din = 4'b0101;
        cycles(1);
        check("t6_rr_zero_grant", 32'(transfer_strobe_dout), 32'h1);
        check("t6_credit_after", 32'(credit_count_dout), 32'd3);
        request_din = 4'b0000;
        cycles(6);
        check("t6_end_idle", 32'(port_busy_dout), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
